// File: rtl/enter_input_port_if.sv
// Datapath-side handshake for the IN instruction.
// The controller is the master. The input port answers on the slave side.
interface enter_input_port_if #(
  parameter int DATA_W = 8
);
  logic              InReq;
  logic              InAck;
  logic [DATA_W-1:0] InData;
  logic              InValid;
  logic              Waiting;

  modport master (output InReq, InAck, input InData, InValid, Waiting);
  modport slave  (input InReq, InAck, output InData, InValid, Waiting);
endinterface

// File: rtl/enter_input_port.sv
// Enter-switch input port.
// The raw Enter switch is synchronised and then debounced.
// A fresh debounced press while the controller is waiting latches the data switches.
// The latched word is held valid until the controller acknowledges it.
// The switch must be released before another word can be captured.
module enter_input_port #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enter_raw,
  input  logic [DATA_W-1:0] Data_sw,
  enter_input_port_if.slave bus
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, HOLD, RELEASE} state_t;

  logic [1:0]        sync_ff;
  logic              sync;
  logic              deb, deb_q;
  logic [CNT_W-1:0]  cnt;
  logic              rise;
  state_t            state, state_nxt;
  logic              capture;
  logic [DATA_W-1:0] in_data_q;

  assign sync = sync_ff[1];
  assign rise = deb & ~deb_q;

  // Two-flop synchroniser for the asynchronous Enter switch
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) sync_ff <= '0;
    else       sync_ff <= {sync_ff[0], Enter_raw};
  end

  // Debounce: change the level only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      deb_q <= deb;
      if (sync == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state. A drop of InReq in ARMED wins over a same-cycle press.
  // HOLD ignores InReq, so an un-acked word is never lost.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      IDLE:    if (bus.InReq) state_nxt = ARMED;
      ARMED: begin
        if (!bus.InReq) begin
          state_nxt = IDLE;
        end else if (rise) begin
          state_nxt = HOLD;
          capture   = 1'b1;
        end
      end
      HOLD:    if (bus.InAck) state_nxt = RELEASE;
      RELEASE: if (!deb) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word register. It keeps its value after the ack until the next capture.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)        in_data_q <= '0;
    else if (capture) in_data_q <= Data_sw;
  end

  assign bus.InData  = in_data_q;
  assign bus.InValid = (state == HOLD);
  assign bus.Waiting = (state == ARMED);
endmodule

// File: tb/tb_enter_input_port.sv
// Bench for enter_input_port with DEBOUNCE_CYCLES=4.
// Expected words are queued when a press is driven.
// Each queued word is popped and compared when InValid is raised.
module tb_enter_input_port;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enter_raw;
  logic [DW-1:0] data_sw;
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q[$];

  enter_input_port_if #(.DATA_W(DW)) bus ();

  enter_input_port #(.DATA_W(DW), .DEBOUNCE_CYCLES(4)) dut (
    .Clock     (clk),
    .Reset     (rst),
    .Enter_raw (enter_raw),
    .Data_sw   (data_sw),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for InValid, then pop the scoreboard and compare InData
  task automatic expect_word(input string name, input int budget);
    bit            seen;
    logic [DW-1:0] exp;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.InValid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: InValid=%b required 1 within %0d cycles", name, bus.InValid, budget);
    end else if (bus.InData !== exp) begin
      errors++;
      $display("FAIL %s_data: InData=%h required %h", name, bus.InData, exp);
    end
  endtask

  // Acknowledge, release Enter and let the FSM get back to ARMED
  task automatic ack_and_release();
    bus.InAck = 1'b1;
    tick(1);
    bus.InAck = 1'b0;
    enter_raw = 1'b0;
    tick(10);
  endtask

  task automatic test_reset();
    checks++;
    if (bus.InValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", bus.InValid); end
    checks++;
    if (bus.InData !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", bus.InData); end
    checks++;
    if (bus.Waiting !== 1'b0) begin errors++; $display("FAIL reset_waiting: got %b required 0", bus.Waiting); end
  endtask

  task automatic test_capture();
    bus.InReq = 1'b1;
    tick(1);
    checks++;
    if (bus.Waiting !== 1'b1) begin errors++; $display("FAIL armed_waiting: got %b required 1", bus.Waiting); end
    data_sw = 8'h5A;
    exp_q.push_back(8'h5A);
    enter_raw = 1'b1;
    tick(6);
    checks++;
    if (bus.InValid !== 1'b0) begin errors++; $display("FAIL latency_early: InValid=%b after edge 6 required 0", bus.InValid); end
    tick(1);
    checks++;
    if (bus.InValid !== 1'b1) begin errors++; $display("FAIL latency_edge7: InValid=%b after edge 7 required 1", bus.InValid); end
    expect_word("capture", 1);
    bus.InAck = 1'b1;
    tick(1);
    bus.InAck = 1'b0;
    checks++;
    if (bus.InValid !== 1'b0) begin errors++; $display("FAIL ack_drop: InValid=%b required 0", bus.InValid); end
    checks++;
    if (bus.InData !== 8'h5A) begin errors++; $display("FAIL data_kept: InData=%h required 5a", bus.InData); end
    enter_raw = 1'b0;
    tick(10);
    checks++;
    if (bus.Waiting !== 1'b1) begin errors++; $display("FAIL rearm: Waiting=%b required 1", bus.Waiting); end
  endtask

  task automatic test_bounce();
    int bad;
    bad = 0;
    data_sw = 8'h77;
    for (int k = 0; k < 5; k++) begin
      enter_raw = 1'b1;
      tick(2);
      if (bus.InValid !== 1'b0) bad++;
      enter_raw = 1'b0;
      tick(2);
      if (bus.InValid !== 1'b0) bad++;
    end
    // An ack while armed must be ignored
    bus.InAck = 1'b1;
    tick(1);
    bus.InAck = 1'b0;
    tick(8);
    checks++;
    if (bad != 0 || bus.InValid !== 1'b0) begin
      errors++;
      $display("FAIL bounce_valid: InValid=%b high_samples=%0d required 0", bus.InValid, bad);
    end
    checks++;
    if (bus.Waiting !== 1'b1) begin errors++; $display("FAIL bounce_armed: Waiting=%b required 1", bus.Waiting); end
  endtask

  task automatic test_held_before_armed();
    int bad;
    bad = 0;
    bus.InReq = 1'b0;
    tick(3);
    data_sw = 8'hAA;
    enter_raw = 1'b1;
    tick(10);
    bus.InReq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.InValid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL held_no_capture: InValid high %0d cycles required 0", bad); end
    checks++;
    if (bus.Waiting !== 1'b1) begin errors++; $display("FAIL held_armed: Waiting=%b required 1", bus.Waiting); end
    enter_raw = 1'b0;
    tick(8);
    data_sw = 8'hC3;
    exp_q.push_back(8'hC3);
    enter_raw = 1'b1;
    expect_word("repress", 20);
    ack_and_release();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] tbl [3];
    tbl[0] = 8'h01;
    tbl[1] = 8'hFE;
    tbl[2] = 8'h96;
    for (int k = 0; k < 3; k++) begin
      data_sw = tbl[k];
      exp_q.push_back(tbl[k]);
      enter_raw = 1'b1;
      expect_word("b2b", 20);
      ack_and_release();
    end
  endtask

  task automatic test_no_req();
    bus.InReq = 1'b0;
    tick(3);
    data_sw = 8'h11;
    enter_raw = 1'b1;
    tick(10);
    checks++;
    if (bus.Waiting !== 1'b0 || bus.InValid !== 1'b0) begin
      errors++;
      $display("FAIL noreq_idle: Waiting=%b InValid=%b required 0 0", bus.Waiting, bus.InValid);
    end
    bus.InReq = 1'b1;
    tick(10);
    checks++;
    if (bus.InValid !== 1'b0 || bus.Waiting !== 1'b1) begin
      errors++;
      $display("FAIL noreq_held: InValid=%b Waiting=%b required 0 1", bus.InValid, bus.Waiting);
    end
    enter_raw = 1'b0;
    tick(8);
    data_sw = 8'h3C;
    exp_q.push_back(8'h3C);
    enter_raw = 1'b1;
    expect_word("noreq_repress", 20);
  endtask

  // Entered in HOLD with 0x3C latched
  task automatic test_hold();
    int bad;
    bad = 0;
    bus.InReq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.InValid !== 1'b1 || bus.InData !== 8'h3C) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_noreq: bad cycles=%0d InValid=%b InData=%h required 1 3c", bad, bus.InValid, bus.InData); end
    data_sw = 8'hFF;
    tick(2);
    checks++;
    if (bus.InData !== 8'h3C) begin errors++; $display("FAIL hold_frozen: InData=%h required 3c", bus.InData); end
  endtask

  // Entered still in HOLD; reset must clear outputs without waiting for a clock edge
  task automatic test_reset_mid_hold();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.InValid !== 1'b0 || bus.InData !== 8'h00 || bus.Waiting !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: InValid=%b InData=%h Waiting=%b required 0 00 0", bus.InValid, bus.InData, bus.Waiting);
    end
    enter_raw = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    checks++;
    if (bus.Waiting !== 1'b0 || bus.InValid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: Waiting=%b InValid=%b required 0 0", bus.Waiting, bus.InValid);
    end
  endtask

  initial begin
    rst = 1'b1;
    enter_raw = 1'b0;
    data_sw = '0;
    bus.InReq = 1'b0;
    bus.InAck = 1'b0;
    tick(2);
    test_reset();
    rst = 1'b0;
    tick(1);
    test_capture();
    test_bounce();
    test_held_before_armed();
    test_back_to_back();
    test_no_req();
    test_hold();
    test_reset_mid_hold();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d words left required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
